// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder/subtractor.
package serial_adder_pkg;

  localparam int unsigned SA_W_MIN = 2;
  localparam int unsigned SA_W_MAX = 32;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_FIN  = 2'd2
  } sa_state_e;

  typedef struct packed {
    logic cout;
    logic ovf;
  } sa_flags_t;

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done bus between a requester and the serial adder.
interface serial_adder_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// 1-bit full adder built from two half adders and an OR.
module fa_cell (
  output logic s,
  output logic co,
  input  logic x,
  input  logic y,
  input  logic ci
);
  logic s1, c1, c2;

  assign s1 = x ^ y;
  assign c1 = x & y;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder/subtractor: LSB-first through one full-adder cell,
// W RUN cycles plus one FIN cycle per operation.
import serial_adder_pkg::*;

module serial_adder #(
  parameter int unsigned W = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = $clog2(W);

  if (W < SA_W_MIN || W > SA_W_MAX) begin : g_bad_w
    $error("serial_adder: W=%0d outside %0d..%0d", W, SA_W_MIN, SA_W_MAX);
  end

  sa_state_e     state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  sa_flags_t     flags_q, flags_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fa_s, fa_co;

  fa_cell u_fa (
    .s  (fa_s),
    .co (fa_co),
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q)
  );

  // Next state: the A register doubles as the sum accumulator, since each
  // A bit is consumed in the same cycle its sum bit is shifted in.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    flags_d = flags_q;

    if (state_q == SA_RUN) begin
      a_d     = {fa_s, a_q[W-1:1]};
      b_d     = {1'b0, b_q[W-1:1]};
      carry_d = fa_co;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) begin
        state_d      = SA_FIN;
        res_d        = {fa_s, a_q[W-1:1]};
        flags_d.cout = fa_co;
        flags_d.ovf  = carry_q ^ fa_co;
        cnt_d        = '0;
      end
    end else if (bus.start) begin
      state_d = SA_RUN;
      a_d     = bus.a;
      b_d     = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub;
      cnt_d   = '0;
    end else begin
      state_d = SA_IDLE;
    end

    busy_d = (state_d == SA_RUN);
    done_d = (state_d == SA_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SA_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;
  assign bus.cout   = flags_q.cout;
  assign bus.ovf    = flags_q.ovf;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at W = 8, 4 and 16 against an arithmetic model.
module tb_serial_adder;

  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic [31:0] done_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n, rst8_n;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;

  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic        start_v [3];
  logic        sub_v [3];
  logic [31:0] res_s [3];
  logic        done_s [3];
  logic        busy_s [3];
  logic        cout_s [3];
  logic        ovf_s [3];
  logic [31:0] last_res [3];

  exp_t q0[$], q1[$], q2[$];

  serial_adder_if #(.W(8))  if8 ();
  serial_adder_if #(.W(4))  if4 ();
  serial_adder_if #(.W(16)) if16 ();

  serial_adder #(.W(8))  u8  (.clk(clk), .rst_n(rst8_n), .bus(if8.slave));
  serial_adder #(.W(4))  u4  (.clk(clk), .rst_n(rst_n),  .bus(if4.slave));
  serial_adder #(.W(16)) u16 (.clk(clk), .rst_n(rst_n),  .bus(if16.slave));

  assign if8.start  = start_v[0];
  assign if8.sub    = sub_v[0];
  assign if8.a      = a_v[0][7:0];
  assign if8.b      = b_v[0][7:0];
  assign if4.start  = start_v[1];
  assign if4.sub    = sub_v[1];
  assign if4.a      = a_v[1][3:0];
  assign if4.b      = b_v[1][3:0];
  assign if16.start = start_v[2];
  assign if16.sub   = sub_v[2];
  assign if16.a     = a_v[2][15:0];
  assign if16.b     = b_v[2][15:0];

  assign res_s[0]  = 32'(if8.result);
  assign res_s[1]  = 32'(if4.result);
  assign res_s[2]  = 32'(if16.result);
  assign done_s[0] = if8.done;
  assign done_s[1] = if4.done;
  assign done_s[2] = if16.done;
  assign busy_s[0] = if8.busy;
  assign busy_s[1] = if4.busy;
  assign busy_s[2] = if16.busy;
  assign cout_s[0] = if8.cout;
  assign cout_s[1] = if4.cout;
  assign cout_s[2] = if16.cout;
  assign ovf_s[0]  = if8.ovf;
  assign ovf_s[1]  = if4.ovf;
  assign ovf_s[2]  = if16.ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned wid(int id);
    case (id)
      0:       return 8;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  // Reference: modular sum from plain integers, overflow from the signed range.
  function automatic exp_t model(int unsigned w, logic [31:0] a, logic [31:0] b, logic sub);
    exp_t e;
    longint unsigned mask, ua, ub, full;
    longint sa, sb, sr, half;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    full = sub ? (ua + ((~ub) & mask) + 64'd1) : (ua + ub);
    half = longint'(64'd1 << (w - 1));
    sa   = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
    sb   = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
    sr   = sub ? sa - sb : sa + sb;
    e.res      = 32'(full & mask);
    e.cout     = full[w];
    e.ovf      = (sr >= half) || (sr < -half);
    e.done_cyc = 32'd0;
    return e;
  endfunction

  task automatic chk(int id, string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [W=%0d] at cycle %0d: got 0x%0h, expected 0x%0h",
               name, wid(id), cyc, act, exp);
    end
  endtask

  task automatic push(int id, exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(int id);
    case (id)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int id = 0; id < 3; id++) begin
      if (done_s[id] === 1'b1) begin
        if (qsize(id) == 0) begin
          chk(id, "unexpected_done", 32'(done_s[id]), 32'd0);
        end else begin
          e = qpop(id);
          chk(id, "result",  res_s[id],         e.res);
          chk(id, "cout",    32'(cout_s[id]),   32'(e.cout));
          chk(id, "ovf",     32'(ovf_s[id]),    32'(e.ovf));
          chk(id, "latency", cyc,               e.done_cyc);
        end
      end
    end
  end

  // One operation; operands and start are scrambled while the block is busy.
  task automatic op(int id, logic [31:0] a, logic [31:0] b, logic sub);
    int unsigned w;
    exp_t e;
    w = wid(id);
    @(negedge clk);
    a_v[id] = a; b_v[id] = b; sub_v[id] = sub; start_v[id] = 1'b1;
    e = model(w, a, b, sub);
    e.done_cyc = cyc + 1 + w;
    push(id, e);
    @(negedge clk);
    start_v[id] = 1'b0;
    chk(id, "busy_after_start", 32'(busy_s[id]), 32'd1);
    chk(id, "result_held", res_s[id], last_res[id]);
    last_res[id] = e.res;
    for (int j = 0; j < int'(w); j++) begin
      a_v[id] = $urandom; b_v[id] = $urandom;
      sub_v[id] = 1'($urandom); start_v[id] = 1'($urandom);
      @(negedge clk);
    end
    start_v[id] = 1'b0;
  endtask

  task automatic random_ops(int id, int n);
    for (int i = 0; i < n; i++) op(id, $urandom, $urandom, 1'($urandom));
  endtask

  task automatic check_outputs_zero(int id, string tag);
    chk(id, {tag, "_busy"},   32'(busy_s[id]), 32'd0);
    chk(id, {tag, "_done"},   32'(done_s[id]), 32'd0);
    chk(id, {tag, "_result"}, res_s[id],       32'd0);
    chk(id, {tag, "_cout"},   32'(cout_s[id]), 32'd0);
    chk(id, {tag, "_ovf"},    32'(ovf_s[id]),  32'd0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    rst8_n = 1'b0;
    for (int id = 0; id < 3; id++) begin
      a_v[id] = '0; b_v[id] = '0; start_v[id] = 1'b0; sub_v[id] = 1'b0;
      last_res[id] = '0;
    end
    repeat (3) @(negedge clk);
    for (int id = 0; id < 3; id++) check_outputs_zero(id, "reset");
    rst_n = 1'b1;
    rst8_n = 1'b1;

    // W=8 directed corners, then random
    op(0, 32'h05, 32'h03, 1'b0);
    op(0, 32'hFF, 32'h01, 1'b0);
    op(0, 32'h7F, 32'h01, 1'b0);
    op(0, 32'h05, 32'h07, 1'b1);
    op(0, 32'h80, 32'h01, 1'b1);
    random_ops(0, 20);

    // Start held high: one operation every W+1 cycles, junk operands between captures
    @(negedge clk);
    start_v[0] = 1'b1;
    for (int t = 0; t < 45; t++) begin
      if (t % 9 == 0) begin
        a_v[0] = $urandom; b_v[0] = $urandom; sub_v[0] = 1'($urandom);
        e = model(8, a_v[0], b_v[0], sub_v[0]);
        e.done_cyc = cyc + 1 + 8;
        push(0, e);
        last_res[0] = e.res;
      end else begin
        a_v[0] = $urandom; b_v[0] = $urandom; sub_v[0] = 1'($urandom);
      end
      @(negedge clk);
    end
    start_v[0] = 1'b0;

    // Reset in the middle of 0xAA+0x55: outputs clear at once, no done follows
    op(0, 32'h81, 32'h33, 1'b0);
    @(negedge clk);
    a_v[0] = 32'hAA; b_v[0] = 32'h55; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst8_n = 1'b0;
    #1 check_outputs_zero(0, "midrun_reset");
    @(negedge clk);
    rst8_n = 1'b1;
    repeat (10) @(negedge clk);
    chk(0, "idle_after_reset", 32'(busy_s[0]), 32'd0);
    last_res[0] = '0;
    op(0, 32'h10, 32'h20, 1'b0);

    // W=4
    op(1, 32'hF, 32'h1, 1'b0);
    op(1, 32'h7, 32'h1, 1'b0);
    op(1, 32'h8, 32'h1, 1'b1);
    random_ops(1, 20);

    // W=16
    op(2, 32'hFFFF, 32'h0001, 1'b0);
    op(2, 32'h7FFF, 32'h0001, 1'b0);
    random_ops(2, 20);

    repeat (4) @(negedge clk);
    for (int id = 0; id < 3; id++) chk(id, "scoreboard_drained", 32'(qsize(id)), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
